// File: rtl/vc_switch_scheduler_if.sv
// Input-port <-> switch-scheduler bundle: SA requests/grant plus downstream credit return.
// master = input_port / credit source side, slave = vc_switch_scheduler.
interface vc_switch_scheduler_if #(
    parameter int VC_NUM  = 2,
    parameter int VC_SIZE = $clog2(VC_NUM)
);
    logic [VC_NUM-1:0]              sa_request_i;
    logic [VC_NUM-1:0][VC_SIZE-1:0] sa_downstream_vc_i;
    logic [VC_NUM-1:0]              tail_i;
    logic                           credit_valid_i;
    logic [VC_SIZE-1:0]             credit_vc_i;
    logic                           sa_valid_o;
    logic [VC_SIZE-1:0]             sa_sel_vc_o;
    logic [VC_NUM-1:0]              credit_avail_o;
    logic                           error_o;

    modport master (
        output sa_request_i, sa_downstream_vc_i, tail_i, credit_valid_i, credit_vc_i,
        input  sa_valid_o, sa_sel_vc_o, credit_avail_o, error_o
    );

    modport slave (
        input  sa_request_i, sa_downstream_vc_i, tail_i, credit_valid_i, credit_vc_i,
        output sa_valid_o, sa_sel_vc_o, credit_avail_o, error_o
    );
endinterface

// File: rtl/vc_switch_scheduler.sv
// Per-input-port first-stage switch allocator: credit-gated round-robin VC pick, one-cycle latency.
// Define VC_SWITCH_SCHEDULER_PACKET_LOCK_EN to hold the grant on one VC from head flit to tail flit.

// One downstream-VC credit counter; saturates at BUFFER_SIZE and flags the overflowing return.
module vc_credit_cnt #(
    parameter int BUFFER_SIZE = 8,
    parameter int CW          = $clog2(BUFFER_SIZE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic consume,
    input  logic ret,
    output logic avail,
    output logic ovf
);
    logic [CW-1:0] cnt_q;
    logic          full;

    assign full  = (cnt_q == CW'(BUFFER_SIZE));
    assign avail = (cnt_q != '0);
    assign ovf   = ret && !consume && full;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= CW'(BUFFER_SIZE);
        else if (consume && !ret)
            cnt_q <= cnt_q - 1'b1;
        else if (ret && !consume && !full)
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

module vc_switch_scheduler #(
    parameter int VC_NUM      = 2,
    parameter int VC_SIZE     = $clog2(VC_NUM),
    parameter int BUFFER_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vc_switch_scheduler_if.slave  sch
);
    typedef struct packed {
        logic               vld;
        logic [VC_SIZE-1:0] vc;
    } grant_t;

    grant_t             gnt;
    logic [VC_NUM-1:0]  elig;
    logic [VC_NUM-1:0]  lock_mask;
    logic [VC_NUM-1:0]  consume;
    logic [VC_NUM-1:0]  ret;
    logic [VC_NUM-1:0]  avail;
    logic [VC_NUM-1:0]  ovf;
    logic [VC_SIZE-1:0] ptr_q;
    logic [VC_SIZE-1:0] ptr_nxt;
    logic               ptr_upd;
    logic               valid_q;
    logic [VC_SIZE-1:0] sel_q;
    logic               err_q;

    // Credit check reads registered counts only; a same-cycle return does not enable a grant.
    always_comb begin
        elig = '0;
        for (int v = 0; v < VC_NUM; v++)
            elig[v] = sch.sa_request_i[v] & avail[sch.sa_downstream_vc_i[v]] & lock_mask[v];
    end

    always_comb begin
        int                 idx;
        logic [VC_SIZE-1:0] idx_v;
        gnt   = '0;
        idx   = 0;
        idx_v = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= VC_NUM)
                idx = idx - VC_NUM;
            idx_v = VC_SIZE'(idx);
            if (!gnt.vld && elig[idx_v]) begin
                gnt.vld = 1'b1;
                gnt.vc  = idx_v;
            end
        end
    end

    assign ptr_nxt = (gnt.vc == VC_SIZE'(VC_NUM - 1)) ? '0 : gnt.vc + 1'b1;

    always_comb begin
        consume = '0;
        if (gnt.vld)
            consume[sch.sa_downstream_vc_i[gnt.vc]] = 1'b1;
    end

    always_comb begin
        ret = '0;
        for (int d = 0; d < VC_NUM; d++)
            ret[d] = sch.credit_valid_i && (sch.credit_vc_i == VC_SIZE'(d));
    end

    for (genvar d = 0; d < VC_NUM; d++) begin : g_cred
        vc_credit_cnt #(.BUFFER_SIZE(BUFFER_SIZE)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .consume (consume[d]),
            .ret     (ret[d]),
            .avail   (avail[d]),
            .ovf     (ovf[d])
        );
    end

`ifdef VC_SWITCH_SCHEDULER_PACKET_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;

    lock_state_t        state_q, state_d;
    logic [VC_SIZE-1:0] lock_vc_q, lock_vc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // While locked only the locked VC can win, so any grant is to lock_vc_q.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        ptr_upd   = gnt.vld;
        case (state_q)
            ST_IDLE: begin
                if (gnt.vld && !sch.tail_i[gnt.vc]) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = gnt.vc;
                end
            end
            ST_LOCKED: begin
                ptr_upd = gnt.vld && sch.tail_i[gnt.vc];
                if (ptr_upd)
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lock_mask = '0;
        for (int v = 0; v < VC_NUM; v++)
            lock_mask[v] = (state_q != ST_LOCKED) || (lock_vc_q == VC_SIZE'(v));
    end
`else
    logic unused_tail;

    assign lock_mask   = '1;
    assign ptr_upd     = gnt.vld;
    assign unused_tail = ^sch.tail_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= gnt.vld;
            if (gnt.vld)
                sel_q <= gnt.vc;
            err_q <= |ovf;
            if (ptr_upd)
                ptr_q <= ptr_nxt;
        end
    end

    assign sch.sa_valid_o     = valid_q;
    assign sch.sa_sel_vc_o    = sel_q;
    assign sch.credit_avail_o = avail;
    assign sch.error_o        = err_q;
endmodule

// File: tb/tb_vc_switch_scheduler.sv
// Bench for vc_switch_scheduler: directed scenarios then random traffic, all checked each cycle
// against a queue/array-level model of the credit and round-robin rules.
module tb_vc_switch_scheduler;
    localparam int VC_NUM  = 2;
    localparam int VC_SIZE = 1;
    localparam int BUF     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_switch_scheduler_if #(.VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE)) bus ();

    vc_switch_scheduler #(.VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE), .BUFFER_SIZE(BUF)) dut (
        .clk (clk),
        .rst (rst),
        .sch (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference state
    int m_cnt[VC_NUM];
    int m_ptr;
    bit m_lock;
    int m_lvc;
    bit e_valid;
    int e_sel;
    bit e_err;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the spec rules to the model using the inputs as they stand now.
    task automatic model_edge();
        int g;
        int cons;
        int rt;
        g = -1;
        if (rst) begin
            for (int d = 0; d < VC_NUM; d++) m_cnt[d] = BUF;
            m_ptr = 0; m_lock = 0; m_lvc = 0;
            e_valid = 0; e_sel = 0; e_err = 0;
            return;
        end
        for (int k = 0; k < VC_NUM; k++) begin
            int v;
            v = (m_ptr + k) % VC_NUM;
            if (g < 0 && bus.sa_request_i[v] && m_cnt[int'(bus.sa_downstream_vc_i[v])] > 0
                && (!m_lock || v == m_lvc))
                g = v;
        end
        e_err = 0;
        for (int d = 0; d < VC_NUM; d++) begin
            cons = (g >= 0 && int'(bus.sa_downstream_vc_i[g]) == d) ? 1 : 0;
            rt   = (bus.credit_valid_i && int'(bus.credit_vc_i) == d) ? 1 : 0;
            if (rt == 1 && cons == 0 && m_cnt[d] == BUF) e_err = 1;
            else m_cnt[d] = m_cnt[d] + rt - cons;
        end
        e_valid = (g >= 0);
        if (g >= 0) begin
            e_sel = g;
`ifdef VC_SWITCH_SCHEDULER_PACKET_LOCK_EN
            if (!m_lock) begin
                m_ptr = (g + 1) % VC_NUM;
                if (!bus.tail_i[g]) begin m_lock = 1; m_lvc = g; end
            end else if (bus.tail_i[g]) begin
                m_lock = 0;
                m_ptr  = (g + 1) % VC_NUM;
            end
`else
            m_ptr = (g + 1) % VC_NUM;
`endif
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("sa_valid", int'(bus.sa_valid_o), int'(e_valid));
        chk("sa_sel_vc", int'(bus.sa_sel_vc_o), e_sel);
        for (int d = 0; d < VC_NUM; d++)
            chk("credit_avail", int'(bus.credit_avail_o[d]), int'(m_cnt[d] != 0));
        chk("error", int'(bus.error_o), int'(e_err));
    endtask

    task automatic idle_inputs();
        bus.sa_request_i   = '0;
        bus.tail_i         = '1;
        bus.credit_valid_i = 1'b0;
        bus.credit_vc_i    = '0;
        for (int v = 0; v < VC_NUM; v++) bus.sa_downstream_vc_i[v] = VC_SIZE'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int flit;
        int gseq[$];
        int ngrant;

        idle_inputs();
        do_reset();
        chk("rst_valid", int'(bus.sa_valid_o), 0);
        chk("rst_avail", int'(bus.credit_avail_o), 3);

        // both VCs requesting, own downstream VCs: strict alternation from VC0
        bus.sa_request_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("alt_sel", int'(bus.sa_sel_vc_o), k % 2);
        end

        // VC1 alone drains downstream VC1, then one returned credit yields one grant
        do_reset();
        bus.sa_request_i = 2'b10;
        repeat (8) cyc();
        cyc();
        chk("drain_valid", int'(bus.sa_valid_o), 0);
        chk("drain_avail1", int'(bus.credit_avail_o[1]), 0);
        bus.credit_valid_i = 1'b1; bus.credit_vc_i = 1'b1;
        cyc();
        bus.credit_valid_i = 1'b0;
        ngrant = 0;
        repeat (3) begin cyc(); ngrant += int'(bus.sa_valid_o); end
        chk("refill_grants", ngrant, 1);

        // return to an empty VC0 in the same cycle as its request: grant only next cycle
        do_reset();
        bus.sa_request_i = 2'b01;
        repeat (8) cyc();
        cyc();
        bus.credit_valid_i = 1'b1; bus.credit_vc_i = 1'b0;
        cyc();
        chk("same_cyc_ret_valid", int'(bus.sa_valid_o), 0);
        bus.credit_valid_i = 1'b0;
        cyc();
        chk("late_grant_valid", int'(bus.sa_valid_o), 1);
        cyc();
        chk("empty_avail0", int'(bus.credit_avail_o[0]), 0);

        // overflowing return on a full counter
        do_reset();
        idle_inputs();
        bus.credit_valid_i = 1'b1; bus.credit_vc_i = 1'b1;
        cyc();
        chk("ovf_err", int'(bus.error_o), 1);
        bus.credit_valid_i = 1'b0;
        cyc();
        chk("ovf_err_clear", int'(bus.error_o), 0);
        chk("ovf_avail", int'(bus.credit_avail_o), 3);

        // VC0 sends a 4-flit packet while VC1 streams single-flit packets
        do_reset();
        flit = 0;
        gseq.delete();
        for (int k = 0; k < 8; k++) begin
            bus.sa_request_i[0] = (flit < 4);
            bus.tail_i[0]       = (flit == 3);
            bus.sa_request_i[1] = 1'b1;
            bus.tail_i[1]       = 1'b1;
            cyc();
            if (bus.sa_valid_o) begin
                gseq.push_back(int'(bus.sa_sel_vc_o));
                if (bus.sa_sel_vc_o == 1'b0) flit++;
            end
        end
        chk("pkt_len", int'(gseq.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
`ifdef VC_SWITCH_SCHEDULER_PACKET_LOCK_EN
            if (i < gseq.size()) chk("pkt_seq", gseq[i], (i < 4) ? 0 : 1);
`else
            if (i < gseq.size()) chk("pkt_seq", gseq[i], i % 2);
`endif
        end

        // reset mid-packet: lock must clear and counts refill
        do_reset();
        bus.sa_request_i = 2'b01; bus.tail_i = 2'b00;
        repeat (5) cyc();
        do_reset();
        chk("midrst_valid", int'(bus.sa_valid_o), 0);
        chk("midrst_avail", int'(bus.credit_avail_o), 3);
        bus.sa_request_i = 2'b10;
        cyc();
        chk("midrst_vc1", int'(bus.sa_valid_o && bus.sa_sel_vc_o == 1'b1), 1);

        // pointer reset: leave pointer at 1, reset, then both request -> VC0 first
        idle_inputs();
        bus.sa_request_i = 2'b01;
        cyc();
        do_reset();
        bus.sa_request_i = 2'b11;
        cyc();
        chk("ptr_rst_sel", int'(bus.sa_sel_vc_o), 0);

        // random traffic with occasional resets
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            rst                = ($urandom_range(63) == 0);
            bus.sa_request_i   = VC_NUM'($urandom);
            for (int v = 0; v < VC_NUM; v++)
                bus.sa_downstream_vc_i[v] = VC_SIZE'($urandom_range(VC_NUM - 1));
            bus.tail_i         = VC_NUM'($urandom);
            bus.credit_valid_i = ($urandom_range(3) == 0);
            bus.credit_vc_i    = VC_SIZE'($urandom_range(VC_NUM - 1));
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
